// File: rtl/fp_add_sub_issue_ctrl_pkg.sv
// Shared types and constants for the FP add/sub issue/writeback controller.
// Holds the float container, the FU occupancy state and the funct7 operation codes.
package fp_add_sub_issue_ctrl_pkg;

    typedef logic [31:0] float_t;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    // RV32F funct7 codes; only FADD/FSUB are legal for this unit.
    typedef enum logic [6:0] {
        FADD = 7'b0000000,
        FSUB = 7'b0000100,
        FMUL = 7'b0001000,
        FDIV = 7'b0001100
    } float_funct7_e;

    localparam int unsigned FP_ADD_LATENCY   = 4;
    localparam float_t      FP_CANONICAL_NAN = 32'h7FC00000;

    function automatic logic is_add_sub(float_funct7_e funct7);
        return (funct7 == FADD) || (funct7 == FSUB);
    endfunction

endpackage

// File: rtl/fp_add_sub_issue_ctrl_tag_pipe.sv
// LATENCY-deep shift register of {valid, tag, bad_op} that tracks the adder pipeline.
// Freezes with the adder when en_i is low; clr_i drops every valid bit.
module fp_tag_pipe #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             in_valid_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             in_bad_i,
    output logic             out_valid_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_bad_o
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] bad_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            bad_q   <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_q[i] <= '0;
            end
        end else if (clr_i) begin
            valid_q <= '0;
        end else if (en_i) begin
            valid_q[0] <= in_valid_i;
            bad_q[0]   <= in_bad_i;
            tag_q[0]   <= in_tag_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                bad_q[i]   <= bad_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_bad_o   = bad_q[LATENCY-1];
    assign out_tag_o   = tag_q[LATENCY-1];

endmodule

// File: rtl/fp_add_sub_issue_ctrl.sv
// Issue/writeback controller for the fixed-latency FP add/sub unit: handshakes,
// stall-aligned tag tracking, stretched FU reset, occupancy count and flush.
module fp_add_sub_issue_ctrl
    import fp_add_sub_issue_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY  = FP_ADD_LATENCY,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned RST_HOLD = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  float_funct7_e    issue_funct7_i,
    input  float_t           issue_op_a_i,
    input  float_t           issue_op_b_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic             flush_i,
    output float_t           fu_op_a_o,
    output float_t           fu_op_b_o,
    output float_funct7_e    fu_funct7_o,
    output logic             fu_clk_en_o,
    output logic             fu_rst_n_o,
    input  float_t           fu_result_i,
    input  logic             fu_underflow_i,
    input  logic             fu_overflow_i,
    input  logic             fu_invalid_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [TAG_W-1:0] wb_tag_o,
    output float_t           wb_result_o,
    output logic [2:0]       wb_flags_o,
    output fu_state_e        fu_state_o
);

    localparam int unsigned CntW  = $clog2(LATENCY + 1);
    localparam int unsigned HoldW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    logic [HoldW-1:0] hold_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             advance;
    logic             accept;
    logic             wb_fire;
    logic             pipe_bad;

    // Counts edges since reset release; FU reset lifts once it saturates.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_q <= '0;
        end else if (hold_q != HoldW'(RST_HOLD)) begin
            hold_q <= hold_q + HoldW'(1);
        end
    end

    assign fu_rst_n_o = (hold_q == HoldW'(RST_HOLD));

    assign advance       = !(wb_valid_o && !wb_ready_i);
    assign fu_clk_en_o   = advance;
    assign issue_ready_o = advance && fu_rst_n_o && !flush_i;
    assign accept        = issue_valid_i && issue_ready_o;
    assign wb_fire       = wb_valid_o && wb_ready_i;

    assign fu_op_a_o   = issue_op_a_i;
    assign fu_op_b_o   = issue_op_b_i;
    assign fu_funct7_o = issue_funct7_i;

    fp_tag_pipe #(
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) u_tag_pipe (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (advance),
        .clr_i       (flush_i),
        .in_valid_i  (accept),
        .in_tag_i    (issue_tag_i),
        .in_bad_i    (!is_add_sub(issue_funct7_i)),
        .out_valid_o (wb_valid_o),
        .out_tag_o   (wb_tag_o),
        .out_bad_o   (pipe_bad)
    );

    assign wb_result_o = pipe_bad ? FP_CANONICAL_NAN : fu_result_i;

    always_comb begin
        wb_flags_o = 3'b000;
        if (wb_valid_o) begin
            wb_flags_o = pipe_bad ? 3'b100 : {fu_invalid_i, fu_overflow_i, fu_underflow_i};
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (accept && !wb_fire) begin
            count_d = count_q + CntW'(1);
        end else if (!accept && wb_fire) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fu_state_o = (count_q != '0) ? BUSY : FREE;

endmodule
